xor_frame_checksum: RTL



---
 rtl/xor_frame_pkg.sv | 15 +
 rtl/xor_word.sv | 12 +
 rtl/xor_frame_checksum.sv | 111 +++++++++++
 3 files changed

// File: rtl/xor_frame_pkg.sv
// Shared types and helpers for the streaming XOR frame checksum.
package xor_frame_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Bits needed to hold a count of 0..max inclusive.
    function automatic int unsigned cnt_w(input int unsigned max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/xor_word.sv
// WIDTH-bit bitwise XOR of two words; purely combinational.
module xor_word #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = a_i ^ b_i;

endmodule

// File: rtl/xor_frame_checksum.sv
// Folds each valid/ready input frame into an XOR checksum with parity, a saturating
// word count and an overflow flag, presented on a valid/ready output port.
module xor_frame_checksum
    import xor_frame_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MAX_WORDS  = 16,
    parameter int unsigned ODD_PARITY = 0,
    localparam int unsigned CW        = cnt_w(MAX_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_overflow
);

    localparam logic [CW-1:0] MaxCount = CW'(MAX_WORDS);
    localparam logic          OddBit   = (ODD_PARITY != 0);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] sum_fold;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             accept;

    xor_word #(
        .WIDTH(WIDTH)
    ) u_fold (
        .a_i(sum_q),
        .b_i(in_data),
        .y_o(sum_fold)
    );

    // Ready comes from the registered state only, so DONE never absorbs input.
    assign in_ready = (state_q == StIdle) || (state_q == StAccum);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sum_d   = in_data;
                    count_d = CW'(1);
                    ovf_d   = 1'b0;
                    state_d = in_last ? StDone : StAccum;
                end
            end
            StAccum: begin
                if (accept) begin
                    sum_d = sum_fold;
                    if (count_q < MaxCount) begin
                        count_d = count_q + CW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    sum_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                sum_d   = '0;
                count_d = '0;
                ovf_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid    = (state_q == StDone);
    assign out_sum      = sum_q;
    assign out_parity   = (^sum_q) ^ OddBit;
    assign out_count    = count_q;
    assign out_overflow = ovf_q;

endmodule
